// File: rtl/pc_seq_ras.sv
// Fetch-stage program-counter sequencer with sequential, jump, branch, stall and
// call/return control through a circular return-address stack.
module pc_seq_ras #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned STEP      = 2,
  parameter int unsigned OFF_W     = 8,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              branch_en,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic              call_en,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int unsigned       PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned       CNT_W   = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_VEC);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]  top;
  logic [PTR_W-1:0]  top_inc;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] off_ext;
  logic              push;
  logic              pop;
  logic              set_ovf;
  logic              set_unf;

  assign pc_inc    = pc + STEP_A;
  assign off_ext   = ADDR_W'($signed(branch_off));
  assign top_inc   = top + PTR_ONE;
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_MAX);

  // Next-PC selection in priority order: stall, ret, call, jump, branch, increment
  always_comb begin
    pc_next = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (stall) begin
      pc_next = pc;
    end else if (ret_en) begin
      if (!ras_empty) begin
        pc_next = ras[top];
        pop     = 1'b1;
      end else begin
        set_unf = 1'b1;
      end
    end else if (call_en) begin
      pc_next = jump_addr;
      push    = 1'b1;
      set_ovf = ras_full;
    end else if (jump_en) begin
      pc_next = jump_addr;
    end else if (branch_en) begin
      pc_next = pc + off_ext;
    end
  end

  // A full stack keeps its count; the push lands on the oldest slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RST_PC;
      top           <= '0;
      count         <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc <= pc_next;
      if (push) begin
        top <= top_inc;
        if (!ras_full) count <= count + CNT_ONE;
      end else if (pop) begin
        top   <= top - PTR_ONE;
        count <= count - CNT_ONE;
      end
      if (set_ovf) ras_overflow  <= 1'b1;
      if (set_unf) ras_underflow <= 1'b1;
    end
  end

  // Stack storage carries no reset; contents are only meaningful below count
  always_ff @(posedge clk) begin
    if (push) ras[top_inc] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_seq_ras.sv
// Self-checking bench for pc_seq_ras: table-driven vectors with a scoreboard queue,
// plus a hand-written asynchronous-reset sequence.
module tb_pc_seq_ras;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       branch_en;
  logic [7:0] branch_off;
  logic       call_en;
  logic       ret_en;
  logic [7:0] pc;
  logic [7:0] pc_next;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_overflow;
  logic       ras_underflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       r;
    logic       s;
    logic       rt;
    logic       c;
    logic       j;
    logic [7:0] ja;
    logic       b;
    logic [7:0] off;
    logic [7:0] e_pc;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] e_pc;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
    logic       e_unf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_seq_ras dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .branch_en    (branch_en),
    .branch_off   (branch_off),
    .call_en      (call_en),
    .ret_en       (ret_en),
    .pc           (pc),
    .pc_next      (pc_next),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%02h required=%02h", name, idx, act, exp);
    end
  endtask

  task automatic v(input logic r, input logic s, input logic rt, input logic c, input logic j,
                   input logic [7:0] ja, input logic b, input logic [7:0] off,
                   input logic [7:0] e_pc, input logic e_empty, input logic e_full,
                   input logic e_ovf, input logic e_unf);
    vec_t t;
    t = '{r, s, rt, c, j, ja, b, off, e_pc, e_empty, e_full, e_ovf, e_unf};
    vecs.push_back(t);
  endtask

  task automatic idle_inputs();
    stall = 0; ret_en = 0; call_en = 0; jump_en = 0; jump_addr = 8'h00;
    branch_en = 0; branch_off = 8'h00;
  endtask

  // Drive each row after negedge, check pc_next before the edge, score the edge result
  task automatic run_vecs(input int base);
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].r; stall = vecs[i].s; ret_en = vecs[i].rt; call_en = vecs[i].c;
      jump_en = vecs[i].j; jump_addr = vecs[i].ja; branch_en = vecs[i].b;
      branch_off = vecs[i].off;
      #1;
      if (!vecs[i].r) chk("pc_next", base + i, pc_next, vecs[i].e_pc);
      sb.push_back('{base + i, vecs[i].e_pc, vecs[i].e_empty, vecs[i].e_full,
                     vecs[i].e_ovf, vecs[i].e_unf});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pc", e.idx, pc, e.e_pc);
      chk("ras_empty", e.idx, 8'(ras_empty), 8'(e.e_empty));
      chk("ras_full", e.idx, 8'(ras_full), 8'(e.e_full));
      chk("ras_overflow", e.idx, 8'(ras_overflow), 8'(e.e_ovf));
      chk("ras_underflow", e.idx, 8'(ras_underflow), 8'(e.e_unf));
    end
    vecs.delete();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    //  r  s  rt c  j  ja     b  off     pc     e  f  o  u
    v(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h02, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h06, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h08, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h0A, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h0C, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h0E, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h10, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 8'h00, 1, 8'hF8, 8'h08, 1, 0, 0, 0);
    v(0, 0, 0, 0, 1, 8'h40, 1, 8'h04, 8'h40, 1, 0, 0, 0);
    v(0, 0, 0, 0, 1, 8'h20, 0, 8'h00, 8'h20, 1, 0, 0, 0);
    v(0, 0, 0, 1, 0, 8'h80, 0, 8'h00, 8'h80, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h22, 1, 0, 0, 0);
    v(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h24, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h26, 1, 0, 0, 1);
    // five nested calls on a four-deep stack, then drain past empty
    v(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    v(0, 0, 0, 1, 0, 8'h10, 0, 8'h00, 8'h10, 0, 0, 0, 0);
    v(0, 0, 0, 1, 0, 8'h20, 0, 8'h00, 8'h20, 0, 0, 0, 0);
    v(0, 0, 0, 1, 0, 8'h30, 0, 8'h00, 8'h30, 0, 0, 0, 0);
    v(0, 0, 0, 1, 0, 8'h40, 0, 8'h00, 8'h40, 0, 1, 0, 0);
    v(0, 0, 0, 1, 0, 8'h50, 0, 8'h00, 8'h50, 0, 1, 1, 0);
    v(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h42, 0, 0, 1, 0);
    v(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h32, 0, 0, 1, 0);
    v(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h22, 0, 0, 1, 0);
    v(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h12, 1, 0, 1, 0);
    v(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h14, 1, 0, 1, 1);
    // stall dominates a pending call, which then executes exactly once
    v(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    v(0, 1, 0, 1, 0, 8'h60, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    v(0, 1, 0, 1, 0, 8'h60, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    v(0, 1, 0, 1, 0, 8'h60, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    v(0, 0, 0, 1, 0, 8'h60, 0, 8'h00, 8'h60, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h62, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1, 8'hFE, 0, 8'h00, 8'hFE, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    v(0, 0, 0, 1, 0, 8'h30, 0, 8'h00, 8'h30, 0, 0, 0, 0);
    v(0, 0, 0, 1, 0, 8'h50, 0, 8'h00, 8'h50, 0, 0, 0, 0);
    run_vecs(0);

    // asynchronous reset in the middle of a cycle, checked before any clock edge
    @(negedge clk);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk("async_pc", 100, pc, 8'h00);
    chk("async_empty", 100, 8'(ras_empty), 8'h01);
    chk("async_full", 100, 8'(ras_full), 8'h00);
    chk("async_ovf", 100, 8'(ras_overflow), 8'h00);
    chk("async_unf", 100, 8'(ras_underflow), 8'h00);

    //  r  s  rt c  j  ja     b  off     pc     e  f  o  u
    v(0, 0, 0, 1, 0, 8'h70, 0, 8'h00, 8'h70, 0, 0, 0, 0);
    v(0, 0, 1, 1, 0, 8'h90, 0, 8'h00, 8'h02, 1, 0, 0, 0);
    v(0, 1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h02, 1, 0, 0, 0);
    v(0, 0, 1, 1, 0, 8'h90, 0, 8'h00, 8'h04, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0, 8'h00, 1, 8'h7F, 8'h83, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0, 8'h00, 1, 8'h80, 8'h03, 1, 0, 0, 1);
    run_vecs(200);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_residue actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
